mb_seq_mult: RTL and testbench

Iterative radix-4 Modified Booth signed multiplier with a start/ready/done handshake. It generates one Booth digit and its partial product per cycle and accumulates all N/2 partial products over N/2 cycles. This is the area-optimised alternative to the fully parallel MB array: it reuses one digit cell and one 2N-bit adder instead of N/2 of each. It sits between the operand registers and the result bus of the arithmetic unit.

---
 rtl/mb_seq_mult_pkg.sv | 25 ++
 rtl/mb_pp_gen.sv | 45 ++++
 rtl/mb_seq_mult.sv | 134 +++++++++++++
 tb/tb_mb_seq_mult.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// mb_seq_mult_pkg
// Shared definitions for the iterative radix-4 Modified Booth multiplier:
// default operand width, iteration counter width, FSM state encodings and
// the record type describing one Booth digit (three overlapping y bits).
// ---------------------------------------------------------------------------
package mb_seq_mult_pkg;

    localparam int MB_N_DEFAULT  = 32;
    localparam int MB_CW_DEFAULT = 5;

    // Plain constants rather than an enum so the encodings stay fixed for
    // any legacy logic that decodes the state bits directly.
    localparam logic [1:0] MB_IDLE = 2'd0;
    localparam logic [1:0] MB_RUN  = 2'd1;
    localparam logic [1:0] MB_FIN  = 2'd2;

    // One Booth digit: y[2i-1] (minus), y[2i] (zero), y[2i+1] (plus).
    typedef struct packed {
        logic bjp;
        logic bjz;
        logic bjm;
    } booth_digit_t;

endpackage

// File: rtl/mb_pp_gen.sv
// ---------------------------------------------------------------------------
// mb_pp_gen
// Combinational Booth digit cell. Recodes one radix-4 digit of the
// multiplier and produces the signed partial product for that digit,
// before any positional shift.
//
// Ports:
//   bjm, bjz, bjp  in   Booth digit bits y[2i-1], y[2i], y[2i+1]
//   xr             in   N-bit latched multiplicand (two's complement)
//   pp             out  N+2-bit signed partial product (0, +-x, +-2x)
// ---------------------------------------------------------------------------
module mb_pp_gen #(
    parameter int N = 32
) (
    input  logic         bjm,
    input  logic         bjz,
    input  logic         bjp,
    input  logic [N-1:0] xr,
    output logic [N+1:0] pp
);

    logic         sign;
    logic         one;
    logic         two;
    logic [N+1:0] m;

    // The magnitude is carried in N+2 bits rather than N+1: negating
    // 2*(-2^(N-1)) gives +2^N, which only fits with one extra bit. Keeping
    // that bit makes the later sign extension to 2N bits exact.
    // The 111 pattern yields sign=0, so it produces +0 rather than -0.
    always_comb begin
        sign = bjp & ~(bjz & bjm);
        one  = bjm ^ bjz;
        two  = ~one & (bjp ^ bjz);
        if (one) begin
            m = {{2{xr[N-1]}}, xr};
        end else if (two) begin
            m = {xr[N-1], xr, 1'b0};
        end else begin
            m = '0;
        end
        pp = sign ? -m : m;
    end

endmodule

// File: rtl/mb_seq_mult.sv
// ---------------------------------------------------------------------------
// mb_seq_mult
// Iterative radix-4 Modified Booth signed multiplier. One Booth digit and
// its partial product are generated per cycle by a single mb_pp_gen cell
// and accumulated into a 2N-bit register over N/2 cycles.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   multiply request, honoured only while ready=1
//   x      in   N-bit multiplicand (two's complement)
//   y      in   N-bit multiplier (two's complement, Booth-recoded)
//   ready  out  high in IDLE; a start is accepted
//   done   out  one-cycle pulse; p valid from this cycle onward
//   p      out  2N-bit signed product, held until the next accepted start
// ---------------------------------------------------------------------------
module mb_seq_mult
    import mb_seq_mult_pkg::*;
#(
    parameter int N  = MB_N_DEFAULT,
    parameter int CW = MB_CW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] p
);

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   xr_q, xr_d;
    logic [N-1:0]   yr_q, yr_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    booth_digit_t   digit;
    logic [N+1:0]   pp;
    logic [2*N-1:0] pp_ext;
    logic [2*N-1:0] pp_shifted;

    // Digit cnt occupies bits [2cnt+1:2cnt-1] of y; appending a zero below
    // y supplies the implicit y[-1]=0 for digit 0, so one right shift by
    // 2*cnt brings the current digit down to bits [2:0].
    always_comb begin
        digit = booth_digit_t'(3'({yr_q, 1'b0} >> {cnt_q, 1'b0}));
    end

    mb_pp_gen #(
        .N(N)
    ) u_pp_gen (
        .bjm(digit.bjm),
        .bjz(digit.bjz),
        .bjp(digit.bjp),
        .xr (xr_q),
        .pp (pp)
    );

    // Sign-extend the digit's partial product to the full product width
    // and weight it by 4^cnt with a barrel shift.
    always_comb begin
        pp_ext     = {{(N-2){pp[N+1]}}, pp};
        pp_shifted = pp_ext << {cnt_q, 1'b0};
    end

    // Next-state logic. Operands are latched at acceptance so later changes
    // on x/y cannot disturb a multiply in flight. p is written only when
    // the final partial product is added, so it keeps the last result
    // through the whole next operation.
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            MB_IDLE: begin
                if (start) begin
                    xr_d    = x;
                    yr_d    = y;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MB_RUN;
                end
            end
            MB_RUN: begin
                acc_d = acc_q + pp_shifted;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N/2 - 1)) begin
                    p_d     = acc_q + pp_shifted;
                    state_d = MB_FIN;
                end
            end
            MB_FIN: begin
                state_d = MB_IDLE;
            end
            default: begin
                state_d = MB_IDLE;
            end
        endcase
    end

    // State registers; reset overrides everything, including a multiply
    // in progress, and leaves the block idle with a cleared product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MB_IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        ready = (state_q == MB_IDLE);
        done  = (state_q == MB_FIN);
        p     = p_q;
    end

endmodule

// File: tb/tb_mb_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_mb_seq_mult
// Self-checking bench for mb_seq_mult (N=32). Directed table vectors,
// hand-written handshake/reset sequences, back-to-back issue and random
// operands compared against a plain signed-multiply reference.
// ---------------------------------------------------------------------------
module tb_mb_seq_mult;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           ready;
    logic           done;
    logic [2*N-1:0] p;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] res;
    logic [63:0] held;
    logic [63:0] expq[$];
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] corners[5];
    int          lat;
    int          low_cnt;
    int          done_seen;
    int          cyc;
    int          n_acc;
    int          last_acc;

    mb_seq_mult #(
        .N (N),
        .CW(5)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .ready(ready),
        .done (done),
        .p    (p)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Reference product: ordinary signed multiplication at 64 bits.
    function automatic logic [63:0] refProduct(input logic [31:0] fa, input logic [31:0] fb);
        longint sa;
        longint sb;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        return 64'(sa * sb);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Issue one multiply from a negedge in IDLE and wait (bounded) for done.
    // Returns the product seen while done is high and the cycle count from
    // acceptance to done.
    task automatic applyStimulus(input logic [31:0] sa, input logic [31:0] sb,
                                 output logic [63:0] r, output int l);
        @(negedge clk);
        checkOutput("ready_before_start", 64'(ready), 64'd1);
        x     = sa;
        y     = sb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l     = 1;
        while (done !== 1'b1 && l < 60) begin
            @(negedge clk);
            l++;
        end
        if (done !== 1'b1) checkOutput("done_timeout", 64'(done), 64'd1);
        r = p;
    endtask

    initial begin
        vecs[0] = '{32'h00000003, 32'h00000005, 64'h000000000000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
        vecs[2] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
        vecs[3] = '{32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
        vecs[4] = '{32'hFFFFFFF9, 32'h00000006, 64'hFFFFFFFFFFFFFFD6};
        vecs[5] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
        vecs[6] = '{32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000};
        vecs[7] = '{32'h00000001, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        corners[0] = 32'h00000000;
        corners[1] = 32'h00000001;
        corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h80000000;
        corners[4] = 32'h7FFFFFFF;

        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 64'(ready), 64'd1);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_p", p, 64'd0);
        rst = 1'b0;

        // 3*5: ready low for 17 cycles, done in cycle 17, ready back after.
        @(negedge clk);
        x     = 32'd3;
        y     = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lat     = 1;
        low_cnt = 0;
        while (lat < 60) begin
            if (ready === 1'b0) low_cnt++;
            if (done === 1'b1) break;
            @(negedge clk);
            lat++;
        end
        checkOutput("first_latency", 64'(lat), 64'd17);
        checkOutput("first_ready_low", 64'(low_cnt), 64'd17);
        checkOutput("first_p", p, 64'h000000000000000F);
        @(negedge clk);
        checkOutput("first_ready_back", 64'(ready), 64'd1);
        checkOutput("first_done_pulse", 64'(done), 64'd0);

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, res, lat);
            checkOutput($sformatf("vec%0d_p", i), res, vecs[i].p);
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
        end

        // Start pulsed (with different operands) in cycle 5 of a run is ignored.
        @(negedge clk);
        x     = 32'h12345678;
        y     = 32'h9ABCDEF0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 60) begin
            if (lat == 5) begin
                x     = 32'd99;
                y     = 32'd99;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput("ignored_start_latency", 64'(lat), 64'd17);
        checkOutput("ignored_start_p", p, refProduct(32'h12345678, 32'h9ABCDEF0));
        held = p;
        repeat (3) @(negedge clk);
        checkOutput("ignored_start_not_queued", 64'(ready), 64'd1);
        checkOutput("ignored_start_p_held", p, held);
        applyStimulus(32'd0, 32'd12345, res, lat);
        checkOutput("zero_times_12345", res, 64'd0);

        // Reset in cycle 8 of a run aborts it; p cleared and no done pulse.
        applyStimulus(32'd3, 32'd5, res, lat);
        checkOutput("pre_abort_p", res, 64'h000000000000000F);
        @(negedge clk);
        x     = 32'h00001111;
        y     = 32'h00002222;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ready", 64'(ready), 64'd1);
        checkOutput("abort_p", p, 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'd0);
        applyStimulus(32'hFFFFFFF9, 32'd6, res, lat);
        checkOutput("after_abort_p", res, 64'hFFFFFFFFFFFFFFD6);

        // Back-to-back: start held high, acceptances 18 cycles apart.
        @(negedge clk);
        cyc      = 0;
        n_acc    = 0;
        last_acc = 0;
        while (n_acc < 5 && cyc < 200) begin
            if (done === 1'b1) begin
                if (expq.size() > 0) checkOutput("b2b_p", p, expq.pop_front());
                else checkOutput("b2b_spurious_done", 64'(done), 64'd0);
            end
            if (ready === 1'b1) begin
                a     = $urandom;
                b     = $urandom;
                x     = a;
                y     = b;
                start = 1'b1;
                expq.push_back(refProduct(a, b));
                if (n_acc > 0) checkOutput("b2b_interval", 64'(cyc - last_acc), 64'd18);
                last_acc = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) checkOutput("b2b_done_timeout", 64'(done), 64'd1);
        else if (expq.size() > 0) checkOutput("b2b_last_p", p, expq.pop_front());
        checkOutput("b2b_accept_count", 64'(n_acc), 64'd5);

        // Random operands, with corner values mixed in.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a = corners[$urandom_range(0, 4)];
            if (i % 4 == 2) b = corners[$urandom_range(0, 4)];
            applyStimulus(a, b, res, lat);
            checkOutput($sformatf("rand%0d_p(x=%h,y=%h)", i, a, b), res, refProduct(a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
